// File: rtl/game_pkg.sv
// Shared types and default parameters for the game-state controller.
package game_pkg;

  // Encoding of the gameover code handed to the overlay stage.
  typedef enum logic [1:0] {
    GO_NONE  = 2'b00,
    GO_TOM   = 2'b01,
    GO_JERRY = 2'b10
  } go_code_t;

  // Round state.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_GAME_TIME_S    = 60;
  localparam int DEF_CATCH_DIST     = 32;

endpackage

// File: rtl/frame_timer.sv
// Frame counter and whole-second countdown for one round.
// sec_wrap is high in the cycle where an enabled tick wraps the frame counter.
module frame_timer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAME_TIME_S    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic       tick,
  output logic       sec_wrap,
  output logic [7:0] time_left
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [CW-1:0] frame_cnt;
  logic          at_last;

  assign at_last  = (frame_cnt == CW'(FRAMES_PER_SEC - 1));
  assign sec_wrap = en & tick & at_last;

  // Count frames on enabled ticks; drop one second per wrap, saturating at 0.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      frame_cnt <= '0;
      time_left <= 8'(GAME_TIME_S);
    end else if (en && tick) begin
      if (at_last) begin
        frame_cnt <= '0;
        if (time_left != 8'd0) time_left <= time_left - 8'd1;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_over_ctl.sv
// Game-state controller: edge detection of vblnk/start, per-frame catch check,
// round FSM and latched winner code for the overlay stage.
//
// Handshake: there is no valid/ready interface here; vblnk and start are
// levels whose rising edges (first sampled high) are the events, and every
// output is registered, so it reflects an event one clock after it is seen.
module game_over_ctl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int GAME_TIME_S    = DEF_GAME_TIME_S,
  parameter int CATCH_DIST     = DEF_CATCH_DIST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic [10:0] tom_x,
  input  logic [10:0] tom_y,
  input  logic [10:0] jerry_x,
  input  logic [10:0] jerry_y,
  output logic [1:0]  gameover,
  output logic [7:0]  time_left,
  output logic        running,
  output logic [1:0]  state_dbg
);

  logic     vblnk_d, start_d;
  logic     tick, go;
  state_t   state_q, state_d;
  go_code_t gameover_q, gameover_d;
  logic     load, en, sec_wrap;

  logic signed [11:0] dx_s, dy_s;
  logic        [11:0] dx, dy;
  logic               catch_hit;

  // Remember previous levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      start_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      start_d <= start;
    end
  end

  assign tick = vblnk & ~vblnk_d;
  assign go   = start & ~start_d;

  // Positions are zero-extended so the 12-bit difference never overflows.
  assign dx_s = $signed({1'b0, tom_x}) - $signed({1'b0, jerry_x});
  assign dy_s = $signed({1'b0, tom_y}) - $signed({1'b0, jerry_y});
  assign dx   = dx_s[11] ? 12'(-dx_s) : 12'(dx_s);
  assign dy   = dy_s[11] ? 12'(-dy_s) : 12'(dy_s);
  assign catch_hit = tick && (dx < 12'(CATCH_DIST)) && (dy < 12'(CATCH_DIST));

  frame_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .GAME_TIME_S   (GAME_TIME_S)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (en),
    .tick     (tick),
    .sec_wrap (sec_wrap),
    .time_left(time_left)
  );

  // State and winner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gameover_q <= GO_NONE;
    end else begin
      state_q    <= state_d;
      gameover_q <= gameover_d;
    end
  end

  // Next state, winner code and timer control. A catch suppresses the timer
  // on its tick, which freezes time_left and gives the catch priority.
  always_comb begin
    state_d    = state_q;
    gameover_d = gameover_q;
    load       = 1'b0;
    en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        load       = 1'b1;
        gameover_d = GO_NONE;
        if (go) state_d = S_RUN;
      end
      S_RUN: begin
        en = ~catch_hit;
        if (catch_hit) begin
          state_d    = S_OVER;
          gameover_d = GO_TOM;
        end else if (sec_wrap && (time_left == 8'd1)) begin
          state_d    = S_OVER;
          gameover_d = GO_JERRY;
        end
      end
      S_OVER: begin
        if (go) begin
          state_d    = S_RUN;
          load       = 1'b1;
          gameover_d = GO_NONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        gameover_d = GO_NONE;
      end
    endcase
  end

  assign gameover  = gameover_q;
  assign running   = (state_q == S_RUN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_game_over_ctl.sv
// Bench for game_over_ctl with FRAMES_PER_SEC=2, GAME_TIME_S=3, CATCH_DIST=32.
module tb_game_over_ctl;

  localparam int FPS = 2;
  localparam int GT  = 3;
  localparam int CD  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        start = 1'b0;
  logic [10:0] tom_x = '0, tom_y = '0, jerry_x = '0, jerry_y = '0;
  logic [1:0]  gameover;
  logic [7:0]  time_left;
  logic        running;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  game_over_ctl #(
    .FRAMES_PER_SEC(FPS),
    .GAME_TIME_S   (GT),
    .CATCH_DIST    (CD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .start    (start),
    .tom_x    (tom_x),
    .tom_y    (tom_y),
    .jerry_x  (jerry_x),
    .jerry_y  (jerry_y),
    .gameover (gameover),
    .time_left(time_left),
    .running  (running),
    .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 over. Time left is derived from ticks counted in
  // the round rather than from a frame counter.
  int m_mode = 0, m_ticks = 0, m_tl = GT, m_go = 0;
  bit m_vb_d = 0, m_st_d = 0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Advance the model with the current inputs, then one clock edge.
  task automatic step();
    bit tk, gg, near;
    tk   = vblnk && !m_vb_d;
    gg   = start && !m_st_d;
    near = (absdiff(int'(tom_x), int'(jerry_x)) < CD) &&
           (absdiff(int'(tom_y), int'(jerry_y)) < CD);
    if (rst) begin
      m_mode = 0; m_ticks = 0; m_tl = GT; m_go = 0; m_vb_d = 0; m_st_d = 0;
    end else begin
      m_vb_d = vblnk;
      m_st_d = start;
      case (m_mode)
        0: begin
          m_tl = GT; m_go = 0;
          if (gg) begin m_mode = 1; m_ticks = 0; end
        end
        1: begin
          if (tk) begin
            if (near) begin
              m_mode = 2; m_go = 1;
            end else begin
              m_ticks++;
              m_tl = GT - m_ticks / FPS;
              if (m_tl == 0) begin m_mode = 2; m_go = 2; end
            end
          end
        end
        default: begin
          if (gg) begin m_mode = 1; m_ticks = 0; m_tl = GT; m_go = 0; end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; vblnk = 1'b0; start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step();
    start = 1'b0;
  endtask

  task automatic pulse_vblnk_hi();
    vblnk = 1'b1; step();
  endtask

  task automatic set_pos(input int tx, input int ty, input int jx, input int jy);
    tom_x = 11'(tx); tom_y = 11'(ty); jerry_x = 11'(jx); jerry_y = 11'(jy);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; step(); step();
    rst = 1'b0;
    checks++;
    if (gameover !== 2'b00 || time_left !== 8'd3 || running !== 1'b0 || state_dbg !== 2'b00) begin
      errors++;
      $display("FAIL reset: go=%0d tl=%0d run=%0d st=%0d want 0/3/0/0", gameover, time_left, running, state_dbg);
    end
    for (int i = 0; i < 10; i++) begin
      pulse_vblnk_hi();
      checks++;
      if (gameover !== 2'b00 || time_left !== 8'd3 || running !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold %0d: go=%0d tl=%0d run=%0d want 0/3/0", i, gameover, time_left, running);
      end
      vblnk = 1'b0; step();
    end
  endtask

  task automatic test_timeout();
    int exp_tl, exp_go;
    do_reset();
    set_pos(100, 100, 400, 300);
    pulse_start();
    checks++;
    if (running !== 1'b1 || time_left !== 8'd3 || gameover !== 2'b00) begin
      errors++;
      $display("FAIL timeout_start: run=%0d tl=%0d go=%0d want 1/3/0", running, time_left, gameover);
    end
    for (int t = 1; t <= 9; t++) begin
      pulse_vblnk_hi();
      exp_tl = (t >= 6) ? 0 : 3 - t / 2;
      exp_go = (t >= 6) ? 2 : 0;
      checks++;
      if (time_left !== 8'(exp_tl) || gameover !== 2'(exp_go) || running !== (t < 6)) begin
        errors++;
        $display("FAIL timeout_tick%0d: tl=%0d go=%0d run=%0d want %0d/%0d/%0d",
                 t, time_left, gameover, running, exp_tl, exp_go, (t < 6));
      end
      vblnk = 1'b0; step();
    end
  endtask

  task automatic test_catch();
    do_reset();
    set_pos(100, 100, 131, 69);
    pulse_start();
    pulse_vblnk_hi();
    checks++;
    if (gameover !== 2'b01 || time_left !== 8'd3 || running !== 1'b0) begin
      errors++;
      $display("FAIL catch_first: go=%0d tl=%0d run=%0d want 1/3/0", gameover, time_left, running);
    end
    vblnk = 1'b0; step();
    // fresh round, dx = 32 is not a catch
    set_pos(100, 100, 132, 100);
    pulse_start();
    pulse_vblnk_hi();
    checks++;
    if (gameover !== 2'b00 || running !== 1'b1 || time_left !== 8'd3) begin
      errors++;
      $display("FAIL catch_dx32: go=%0d run=%0d tl=%0d want 0/1/3", gameover, running, time_left);
    end
    vblnk = 1'b0; step();
    // dy = 32 is not a catch either; second tick wraps a second
    set_pos(100, 100, 131, 68);
    pulse_vblnk_hi();
    checks++;
    if (gameover !== 2'b00 || running !== 1'b1 || time_left !== 8'd2) begin
      errors++;
      $display("FAIL catch_dy32: go=%0d run=%0d tl=%0d want 0/1/2", gameover, running, time_left);
    end
    vblnk = 1'b0; step();
    // moving between ticks has no effect until the next tick
    set_pos(100, 100, 100, 100);
    step();
    set_pos(100, 100, 131, 69);
    pulse_vblnk_hi();
    checks++;
    if (gameover !== 2'b01 || time_left !== 8'd2) begin
      errors++;
      $display("FAIL catch_late: go=%0d tl=%0d want 1/2", gameover, time_left);
    end
    vblnk = 1'b0; step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_pos(100, 100, 400, 300);
    pulse_start();
    for (int t = 1; t <= 5; t++) begin
      pulse_vblnk_hi(); vblnk = 1'b0; step();
    end
    set_pos(100, 100, 110, 110);
    pulse_vblnk_hi();
    checks++;
    if (gameover !== 2'b01 || time_left !== 8'd1 || running !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: go=%0d tl=%0d run=%0d want 1/1/0", gameover, time_left, running);
    end
    vblnk = 1'b0; step();
  endtask

  task automatic test_restart();
    int k;
    int exp_tl;
    set_pos(100, 100, 400, 300);
    start = 1'b1; step();
    checks++;
    if (gameover !== 2'b00 || time_left !== 8'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart: go=%0d tl=%0d run=%0d want 0/3/1", gameover, time_left, running);
    end
    k = 0;
    for (int i = 0; i < 20; i++) begin
      vblnk = (i % 2 == 0);
      step();
      if (vblnk) k++;
      exp_tl = (k >= 6) ? 0 : 3 - k / 2;
      checks++;
      if (time_left !== 8'(exp_tl) || running !== (k < 6) || gameover !== ((k >= 6) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL restart_hold %0d: tl=%0d run=%0d go=%0d want tl=%0d", i, time_left, running, gameover, exp_tl);
      end
    end
    start = 1'b0; vblnk = 1'b0; step();
  endtask

  task automatic test_tick_go_same();
    do_reset();
    set_pos(100, 100, 400, 300);
    vblnk = 1'b1; start = 1'b1; step();
    vblnk = 1'b0; start = 1'b0;
    checks++;
    if (running !== 1'b1 || time_left !== 8'd3) begin
      errors++;
      $display("FAIL tick_go_enter: run=%0d tl=%0d want 1/3", running, time_left);
    end
    step();
    pulse_vblnk_hi(); vblnk = 1'b0; step();
    checks++;
    if (time_left !== 8'd3) begin
      errors++;
      $display("FAIL tick_go_uncounted: tl=%0d want 3", time_left);
    end
    pulse_vblnk_hi(); vblnk = 1'b0; step();
    checks++;
    if (time_left !== 8'd2) begin
      errors++;
      $display("FAIL tick_go_second: tl=%0d want 2", time_left);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_pos(100, 100, 400, 300);
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      pulse_vblnk_hi(); vblnk = 1'b0; step();
    end
    rst = 1'b1; step();
    rst = 1'b0;
    checks++;
    if (state_dbg !== 2'b00 || time_left !== 8'd3 || gameover !== 2'b00 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: st=%0d tl=%0d go=%0d run=%0d want 0/3/0/0", state_dbg, time_left, gameover, running);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      vblnk = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      tom_x   = 11'($urandom_range(0, 90));
      tom_y   = 11'($urandom_range(0, 90));
      jerry_x = 11'($urandom_range(0, 90));
      jerry_y = 11'($urandom_range(0, 90));
      step();
      checks++;
      if (gameover !== 2'(m_go) || time_left !== 8'(m_tl) || running !== (m_mode == 1) ||
          state_dbg !== 2'(m_mode)) begin
        errors++;
        $display("FAIL random %0d: go=%0d tl=%0d run=%0d st=%0d want go=%0d tl=%0d mode=%0d",
                 i, gameover, time_left, running, state_dbg, m_go, m_tl, m_mode);
      end
    end
    rst = 1'b0; start = 1'b0; vblnk = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_timeout();
    test_catch();
    test_simultaneous();
    test_restart();
    test_tick_go_same();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
